// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 16;
  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT + 1);

  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it does not borrow.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The partial remainder stays below the divisor, so it needs only WIDTH
  // bits; the trial value needs one more, and a non-borrowing difference
  // always fits back into WIDTH bits.
  assign w_trial = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, i_divisor});
  assign w_diff  = w_trial[WIDTH-1:0] - i_divisor;

  // Select restored or subtracted remainder and the new quotient bit.
  always_comb begin
    o_rem = w_trial[WIDTH-1:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (w_ge) begin
      o_rem = w_diff;
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div32u_restoring_seq.sv
// Sequential unsigned restoring divider (2W / W), one quotient bit per cycle,
// with valid/ready handshakes on operand input and result output.
module div32u_restoring_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo_work;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_accept;
  logic             w_dz;
  logic             w_exc;
  logic             w_last;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_hi     = dividend[2*WIDTH-1:WIDTH];
  assign w_dz     = (divisor == '0);
  assign w_exc    = w_dz || (w_hi >= divisor);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo_work),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; exceptions skip the iteration phase entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_exc ? DONE : CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo_work  <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            r_cnt     <= '0;
            if (w_exc) begin
              r_quotient  <= '1;
              r_remainder <= dividend[WIDTH-1:0];
              r_dbz       <= w_dz;
              r_ovf       <= ~w_dz;
            end else begin
              r_rem      <= w_hi;
              r_quo_work <= dividend[WIDTH-1:0];
              r_dbz      <= 1'b0;
              r_ovf      <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem      <= w_step_rem;
          r_quo_work <= w_step_quo;
          r_cnt      <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quotient  <= w_step_quo;
            r_remainder <= w_step_rem;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/div32u_restoring_seq.md
# div32u_restoring_seq

Sequential unsigned restoring divider: 2·WIDTH-bit dividend by WIDTH-bit divisor, producing a WIDTH-bit quotient and remainder, one quotient bit per cycle. It is the inverse companion of the registered 16×16 unsigned multipliers in the multiplier suite. It sits behind valid/ready handshakes on both sides, so it can be chained with a registered multiplier for `a == (a*b)/b` round-trip checks and characterised with the same PPA flow.

## Interface
- `WIDTH`, default 16: divisor, quotient and remainder width; dividend is 2·WIDTH.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: dividend/divisor valid.
- `in_ready` output 1: block can accept an operand pair.
- `dividend` input 2·WIDTH: unsigned dividend.
- `divisor` input WIDTH: unsigned divisor.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `quotient` output WIDTH: unsigned quotient.
- `remainder` output WIDTH: unsigned remainder.
- `div_by_zero` output 1: divisor was 0.
- `overflow` output 1: divisor ≠ 0 and quotient does not fit in WIDTH bits.

## Operation
- FSM states: IDLE, CALC, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- Accept when `in_valid && in_ready`. Capture the operands into internal registers. Outputs never depend combinationally on the inputs.
- Exception check at acceptance, with H = dividend[2W-1:W]:
  - divisor == 0: set `div_by_zero`=1, `overflow`=0.
  - Otherwise, H ≥ divisor: set `overflow`=1.
  - Either case: `quotient` = all ones, `remainder` = dividend[W-1:0], go directly to DONE.
- Normal case: R (W+1 bits) ← {0,H}; Q ← dividend[W-1:0]; count ← 0; go to CALC.
- Each CALC cycle:
  - T = {R[W-1:0], Q[W-1]}.
  - If T ≥ divisor: R ← T − divisor and shift 1 into Q.
  - Else: R ← T and shift 0 into Q.
  - count++.
- Invariant R < divisor, so T < 2·divisor and fits in W+1 bits.
- After the W-th iteration go to DONE with `quotient` = Q and `remainder` = R[W-1:0]. Both flags are 0.
- DONE: hold all outputs stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- No input is accepted in the same cycle as the output handshake.
- `in_valid` while busy is ignored. The source holds its data until `in_ready`.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE, `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `overflow`=0, count=0. `in_ready` reads 1, but nothing is accepted while `rst_n` is low.
- Normal latency: acceptance at edge k gives `out_valid` high after edge k+W (16 cycles by default).
- Exception latency: `out_valid` high after edge k (the next cycle).
- Output handshake at edge m: `out_valid` low and `in_ready` high after edge m.
- Peak throughput: one division per W+2 cycles with `out_ready` tied high.
- Reset asserted mid-CALC or in DONE aborts the operation. No result is emitted and no stale `out_valid` appears after release.
- Values on `quotient`/`remainder`/flags outside DONE are don't-care for checking, but must be deterministic.

## Structure
- Package `div_pkg`:
  - `div_state_e` enum (IDLE, CALC, DONE).
  - `DIV_WIDTH_DEFAULT` = 16.
  - Counter width constant $clog2(WIDTH+1).
- Sub-module `div_restore_step`: purely combinational single iteration. Inputs are R, Q and divisor; outputs are next R and next Q. It is instantiated once in the top.
- Top holds the FSM, count, operand registers and output registers.

## Test plan
- 100 / 7 → quotient 14, remainder 2, flags 0, `out_valid` exactly 16 cycles after acceptance.
- 0xFFFE0001 / 0xFFFF → quotient 0xFFFF, remainder 0x0000, flags 0. Also 0x0000FFFF / 0x0001 → quotient 0xFFFF, remainder 0.
- 0x12345678 / 0 → `div_by_zero`=1, `overflow`=0, quotient 0xFFFF, remainder 0x5678, `out_valid` one cycle after acceptance.
- 0x00010000 / 0x0001 → `overflow`=1, quotient 0xFFFF, remainder 0x0000.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0 throughout. A second `in_valid` issued meanwhile is accepted only after the output handshake.
- Reset mid-CALC, then release with no new input → `out_valid` stays 0 and the next operation, 1000 / 3, gives quotient 333, remainder 1.
- Random sweep against a reference model: check quotient·divisor + remainder == dividend and remainder < divisor for every non-exception case.
